// File: rtl/qdes_pkg.sv
// qdes_pkg: shared types and constants for the quotient deserializer.
// Optional feature macro used by the design: QDES_FRAME_CHECK_EN.
package qdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int QDES_DEPTH = 2;

    // Bit counter must be able to represent 0..WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/quotient_deser_if.sv
// quotient_deser_if: serial input and parallel output handshake bundle.
// slave = deserializer view, master = divider/consumer (environment) view.
interface quotient_deser_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             overflow;
    logic             frame_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, overflow, frame_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, overflow, frame_err
    );
endinterface

// File: rtl/qdes_fifo2.sv
// qdes_fifo2: 2-entry word buffer with 1-bit pointers and a 2-bit count.
// A push while full is accepted only if a pop happens in the same cycle.
module qdes_fifo2
    import qdes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [QDES_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign valid_o = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'(QDES_DEPTH));
    assign rdata_o = mem_q[rd_ptr_q];

    assign rd_en = pop_i && valid_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = ~wr_ptr_q;
        if (rd_en) rd_ptr_d = ~rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and count; reset clears storage so out_data reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/quotient_deser.sv
// quotient_deser: collects an MSB-first serial quotient into WIDTH-bit words
// and buffers them behind a valid/ready handshake.
// Optional feature macro: QDES_FRAME_CHECK_EN (in_valid gap aborts the frame
// and pulses frame_err; otherwise a gap just pauses accumulation).
module quotient_deser
    import qdes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    quotient_deser_if.slave          bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             overflow_q, overflow_d;

    assign pop = bus.out_valid && bus.out_ready;

    // Next-state logic for the frame FSM, counter and shift register.
`ifdef QDES_FRAME_CHECK_EN
    logic abort_d;
    logic frame_err_q;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        word_d  = {sr_q, bus.in_data};
        push    = 1'b0;
`ifdef QDES_FRAME_CHECK_EN
        abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = '0;
                    sr_d[0] = bus.in_data;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.in_valid) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sr_d  = word_d[WIDTH-2:0];
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
`ifdef QDES_FRAME_CHECK_EN
                    cnt_d   = '0;
                    state_d = IDLE;
                    abort_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A word is lost only when the buffer is full and nothing leaves this cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (push && full && !pop) overflow_d = 1'b1;
    end

    // Frame state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef QDES_FRAME_CHECK_EN
    // Registered one-cycle abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= abort_d;
    end
    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.overflow = overflow_q;

    qdes_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (word_d),
        .rdata_o (bus.out_data),
        .valid_o (bus.out_valid),
        .full_o  (full)
    );
endmodule

// File: tb/tb_quotient_deser.sv
// tb_quotient_deser: directed table, hand sequences and random traffic,
// all checked against a queue-based behavioural model.
module tb_quotient_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quotient_deser_if #(.WIDTH(W)) bus ();
    quotient_deser #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Behavioural model: pending serial bits and buffered words.
    int        m_bits[$];
    logic [W-1:0] m_q[$];
    logic      m_ovf = 1'b0;
    logic      m_err = 1'b0;

    typedef struct {
        logic         v, d, r;
        logic         exp_valid;
        logic [W-1:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic d, input logic r);
        logic         pop, push;
        logic [W-1:0] w;
        pop   = r && (m_q.size() != 0);
        push  = 1'b0;
        m_err = 1'b0;
        w     = '0;
        if (v) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() == W) begin
                foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
                m_bits.delete();
                push = 1'b1;
            end
        end else if (m_bits.size() != 0) begin
`ifdef QDES_FRAME_CHECK_EN
            m_bits.delete();
            m_err = 1'b1;
`endif
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_cmp();
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    endtask

    // One clock: drive, let the edge happen, update model, compare.
    task automatic cyc(input logic v, input logic d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        model_step(v, d, r);
        #1;
        model_cmp();
    endtask

    task automatic send(input logic [W-1:0] w, input logic r);
        for (int i = W - 1; i >= 0; i--) cyc(1'b1, w[i], r);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tbl[10];
    logic [W-1:0] hold;

    initial begin
        bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_ferr", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;

        // Single frame 0xB2 (bits 1,0,1,1,0,0,1,0), consumer always ready.
        for (int i = 0; i < 8; i++) begin
            tbl[i].v = 1'b1; tbl[i].d = ((8'hB2 >> (7 - i)) & 8'd1) != 0; tbl[i].r = 1'b1;
            tbl[i].exp_valid = 1'b0; tbl[i].exp_data = 8'h00;
        end
        tbl[7].exp_valid = 1'b1; tbl[7].exp_data = 8'hB2;
        tbl[8] = '{v:1'b0, d:1'b0, r:1'b1, exp_valid:1'b0, exp_data:8'h00};
        tbl[9] = '{v:1'b0, d:1'b0, r:1'b1, exp_valid:1'b0, exp_data:8'h00};
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].exp_data));
        end

        // Back-to-back with stall: third word is dropped.
        send(8'h3C, 1'b0);
        send(8'h81, 1'b0);
        send(8'hFF, 1'b0);
        chk("b2b_head", 32'(bus.out_data), 32'h3C);
        chk("b2b_ovf", 32'(bus.overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b_second", 32'(bus.out_data), 32'h81);
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b_empty", 32'(bus.out_valid), 32'd0);
        chk("b2b_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Async reset with one buffered word and a 3-bit partial frame.
        send(8'h77, 1'b0);
        cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ovf", 32'(bus.overflow), 32'd0);
        do_reset();
        send(8'hA5, 1'b0);
        chk("post_rst_data", 32'(bus.out_data), 32'hA5);
        cyc(1'b0, 1'b0, 1'b1);

        // Full buffer, pop exactly on the completing edge of the next word.
        do_reset();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        for (int i = W - 1; i >= 1; i--) cyc(1'b1, (8'h33 >> i) & 8'd1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("pp_ovf", 32'(bus.overflow), 32'd0);
        chk("pp_head", 32'(bus.out_data), 32'h22);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pp_next", 32'(bus.out_data), 32'h33);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pp_empty", 32'(bus.out_valid), 32'd0);

        // Gap inside frame 0xC3.
        do_reset();
        for (int i = 7; i >= 4; i--) cyc(1'b1, (8'hC3 >> i) & 8'd1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
`ifdef QDES_FRAME_CHECK_EN
        chk("gap_err_pulse", 32'(bus.frame_err), 32'd1);
`endif
        cyc(1'b0, 1'b0, 1'b0);
        chk("gap_err_clear", 32'(bus.frame_err), 32'd0);
        for (int i = 3; i >= 0; i--) cyc(1'b1, (8'hC3 >> i) & 8'd1, 1'b0);
`ifdef QDES_FRAME_CHECK_EN
        chk("gap_no_word", 32'(bus.out_valid), 32'd0);
`else
        chk("gap_valid", 32'(bus.out_valid), 32'd1);
        chk("gap_word", 32'(bus.out_data), 32'hC3);
`endif

        // Stall hold while more bits stream in.
        do_reset();
        send(8'h5A, 1'b0);
        hold = bus.out_data;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            chk("hold_data", 32'(bus.out_data), 32'(hold));
        end
        chk("hold_val", 32'(hold), 32'h5A);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) != 0);
            if (i == 1500) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
